// File: rtl/carro_scheduler.sv
// Enemy-car slot sequencer: once per frame walks every slot, advances or retires it, then tries one spawn.
// Optional CARRO_SPEEDUP_EN adds a saturating speed bonus that grows every 8 successful spawns.
module carro_scheduler #(
    parameter int NUM_CARS     = 4,
    parameter int SCREEN_H     = 480,
    parameter int SPAWN_GAP    = 90,
    parameter int LANE_LEFT_X  = 100,
    parameter int LANE_RIGHT_X = 300
) (
    input  logic                iClk,
    input  logic                iRst_n,
    input  logic                iFrameTick,
    input  logic                iStart,
    input  logic                iStop,
    input  logic                iPause,
    input  logic [2:0]          iSpeed,
    output logic [2:0]          oSlotSel,
    output logic                oEnable,
    output logic                oSalto,
    output logic [8:0]          oPosicionX,
    output logic [8:0]          oPosicionY,
    output logic [NUM_CARS-1:0] oActiveMask,
    output logic                oBusy,
    output logic                oOverrun
);
    localparam int IDX_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_CARS - 1);
    localparam logic [9:0] SCREEN_LIM = 10'(SCREEN_H);
    localparam logic [8:0] X_LEFT     = 9'(LANE_LEFT_X);
    localparam logic [8:0] X_RIGHT    = 9'(LANE_RIGHT_X);
    localparam logic [7:0] GAP        = 8'(SPAWN_GAP);

    typedef enum logic [1:0] {IDLE, WAIT, SCAN, SPAWN} state_t;

    state_t              state;
    logic [8:0]          posY [NUM_CARS];
    logic [NUM_CARS-1:0] lane;
    logic [7:0]          spawnCnt;
    logic [7:0]          lfsr;
    logic [IDX_W-1:0]    slotIdx;
    logic [IDX_W-1:0]    freeIdx;
    logic                freeFound;
    logic [2:0]          effSpeed;
    logic [9:0]          sum;

    // Lowest-index free slot is the spawn target.
    always_comb begin
        freeFound = 1'b0;
        freeIdx   = '0;
        for (int i = NUM_CARS - 1; i >= 0; i--) begin
            if (!oActiveMask[i]) begin
                freeFound = 1'b1;
                freeIdx   = IDX_W'(i);
            end
        end
    end

    assign sum = {1'b0, posY[slotIdx]} + {7'b0, effSpeed};

`ifdef CARRO_SPEEDUP_EN
    logic [2:0] bonus;
    logic [2:0] spawnTally;
    logic       spawnOk;

    function automatic logic [2:0] satSpeed(input logic [3:0] s);
        return (s > 4'd7) ? 3'd7 : s[2:0];
    endfunction

    assign spawnOk  = (state == SPAWN) && !iStop && (spawnCnt == 8'd1) && freeFound;
    assign effSpeed = satSpeed({1'b0, iSpeed} + {1'b0, bonus});

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            bonus      <= '0;
            spawnTally <= '0;
        end else if (iStop) begin
            bonus      <= '0;
            spawnTally <= '0;
        end else if (spawnOk) begin
            spawnTally <= spawnTally + 3'd1;
            if (spawnTally == 3'd7 && bonus != 3'd7)
                bonus <= bonus + 3'd1;
        end
    end
`else
    assign effSpeed = iSpeed;
`endif

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state       <= IDLE;
            slotIdx     <= '0;
            spawnCnt    <= GAP;
            lfsr        <= 8'hA5;
            lane        <= '0;
            oActiveMask <= '0;
            oSlotSel    <= '0;
            oEnable     <= 1'b0;
            oSalto      <= 1'b0;
            oPosicionX  <= '0;
            oPosicionY  <= '0;
            oBusy       <= 1'b0;
            oOverrun    <= 1'b0;
            for (int i = 0; i < NUM_CARS; i++) posY[i] <= '0;
        end else begin
            lfsr    <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            oEnable <= 1'b0;
            oSalto  <= 1'b0;
            if (iFrameTick && (state == SCAN || state == SPAWN))
                oOverrun <= 1'b1;
            if (iStop) begin
                state       <= IDLE;
                slotIdx     <= '0;
                spawnCnt    <= GAP;
                lane        <= '0;
                oActiveMask <= '0;
                oBusy       <= 1'b0;
                oOverrun    <= 1'b0;
                for (int i = 0; i < NUM_CARS; i++) posY[i] <= '0;
            end else begin
                case (state)
                    IDLE: if (iStart) state <= WAIT;
                    WAIT: begin
                        if (iFrameTick && !iPause) begin
                            state   <= SCAN;
                            slotIdx <= '0;
                            oBusy   <= 1'b1;
                        end
                    end
                    SCAN: begin
                        if (oActiveMask[slotIdx]) begin
                            oSlotSel   <= 3'(slotIdx);
                            oPosicionX <= lane[slotIdx] ? X_RIGHT : X_LEFT;
                            if (sum >= SCREEN_LIM) begin
                                oActiveMask[slotIdx] <= 1'b0;
                                posY[slotIdx]        <= '0;
                                oSalto               <= 1'b1;
                                oPosicionY           <= '0;
                            end else begin
                                posY[slotIdx] <= sum[8:0];
                                oEnable       <= 1'b1;
                                oPosicionY    <= sum[8:0];
                            end
                        end
                        if (slotIdx == LAST_SLOT) state <= SPAWN;
                        else slotIdx <= slotIdx + IDX_W'(1);
                    end
                    SPAWN: begin
                        state   <= WAIT;
                        oBusy   <= 1'b0;
                        slotIdx <= '0;
                        if (spawnCnt == 8'd1) begin
                            // Counter reloads whether or not a slot was free.
                            spawnCnt <= GAP;
                            if (freeFound) begin
                                oActiveMask[freeIdx] <= 1'b1;
                                posY[freeIdx]        <= '0;
                                lane[freeIdx]        <= lfsr[0];
                                oEnable              <= 1'b1;
                                oSlotSel             <= 3'(freeIdx);
                                oPosicionX           <= lfsr[0] ? X_RIGHT : X_LEFT;
                                oPosicionY           <= '0;
                            end
                        end else begin
                            spawnCnt <= spawnCnt - 8'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/carro_scheduler.md
Name: carro_scheduler

Overview:
Sequencer for the enemy-car position registers in the game datapath. Once per video frame it walks NUM_CARS car slots, one per clock. For each slot it advances the Y position, retires cars that leave the screen, and spawns new cars into free slots on a lane taken from an LFSR. It drives the per-car load strobes (enable / jump) and the X/Y seed values that the car registers latch.

Parameters:
NUM_CARS, 4, number of car slots (2..8)
SCREEN_H, 480, Y value at or beyond which a car is retired
SPAWN_GAP, 90, frames between spawn attempts (1..255)
LANE_LEFT_X, 100, X seed for left lane (must be <200)
LANE_RIGHT_X, 300, X seed for right lane (must be >=256)

Ports:
iClk  in  1  system clock
iRst_n  in  1  asynchronous active-low reset
iFrameTick  in  1  one-cycle pulse per video frame
iStart  in  1  pulse; leaves IDLE
iStop  in  1  pulse; returns to IDLE, clears all slots
iPause  in  1  level; frame ticks ignored while high
iSpeed  in  3  pixels per frame added to every active car
oSlotSel  out  3  index of slot addressed by the current strobe
oEnable  out  1  one-cycle strobe: slot oSlotSel latches oPosicionX/oPosicionY
oSalto  out  1  one-cycle strobe: slot oSlotSel is retired (Y cleared)
oPosicionX  out  9  X seed for the addressed slot
oPosicionY  out  9  Y value for the addressed slot
oActiveMask  out  NUM_CARS  bit i = slot i holds a live car
oBusy  out  1  high outside IDLE and WAIT
oOverrun  out  1  sticky; frame tick arrived while busy

Behaviour:
- Reset values: all outputs 0. Internal Y registers 0, lane bits 0, spawn counter = SPAWN_GAP, LFSR = 8'hA5. FSM in IDLE.
- FSM states: IDLE, WAIT, SCAN, SPAWN.
- IDLE -> WAIT on iStart. iStart in any other state is ignored.
- WAIT -> SCAN on iFrameTick & !iPause, with slot index = 0.
- SCAN visits one slot per cycle:
  - Inactive slot: no strobe.
  - Active slot: compute sum = Y + iSpeed in 10 bits.
  - If sum >= SCREEN_H: clear the active bit, pulse oSalto, oPosicionY = 0.
  - Otherwise: store sum, pulse oEnable, oPosicionY = sum[8:0], oPosicionX = lane seed.
  - After slot NUM_CARS-1 -> SPAWN.
- SPAWN is one cycle:
  - Decrement the spawn counter.
  - If it reaches 0: reload SPAWN_GAP. If any slot is free, activate the lowest-index free slot: Y = 0, lane = LFSR[0] (0 = left, 1 = right), pulse oEnable with Y = 0.
  - If no slot is free, the spawn is dropped. The counter still reloads.
  - -> WAIT.
- Frame latency: the last strobe occurs NUM_CARS+1 cycles after the tick.
- Strobes are registered. oSlotSel, oPosicionX and oPosicionY are valid in the same cycle as the strobe. oEnable and oSalto are never high together.
- iFrameTick while in SCAN or SPAWN: the tick is discarded and oOverrun is set. oOverrun clears only on reset or iStop.
- iStop in any state: next cycle IDLE. oActiveMask = 0, no strobe issued, spawn counter reloads, oOverrun cleared.
- iStop and iStart in the same cycle: iStop wins.
- iSpeed = 0: cars still get oEnable strobes with unchanged Y.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every clock outside reset, so lane choice depends on elapsed cycles.
- Asynchronous reset mid-SCAN: everything returns to reset values immediately. No partial strobe.

Optional Feature:
CARRO_SPEEDUP_EN
- Defined: an internal 3-bit speed bonus increments (saturating at 7) after every 8 successful spawns. The effective speed is min(iSpeed + bonus, 7), computed in 4 bits then saturated. The bonus clears on reset and on iStop.
- Undefined: effective speed = iSpeed; no bonus logic.

Test Plan:
- Reset, iStart, SPAWN_GAP = 2, iSpeed = 0, two ticks -> on the 2nd tick's SPAWN cycle oEnable for slot 0, oPosicionY = 0, oActiveMask = 4'b0001.
- One car active at Y = 470, iSpeed = 5 -> next frame oEnable Y = 475. The following frame oSalto for slot 0 and the mask bit clears.
- All 4 slots active, spawn counter expires -> no strobe in SPAWN, counter reloads to SPAWN_GAP, mask stays 4'b1111.
- iFrameTick asserted 2 cycles after a previous tick -> oOverrun = 1, scan completes normally, no extra scan.
- iPause high across 3 ticks -> no strobes, Y unchanged. Release, next tick -> strobes resume.
- iRst_n low mid-SCAN at slot 2 -> all outputs 0 immediately. With CARRO_SPEEDUP_EN and 8 spawns at iSpeed = 3 -> Y increments by 4.
